// File: rtl/reglist_sequencer_pkg.sv
// Shared definitions for the register-list transfer sequencer.
//   op_t     : PUSH / POP / STMIA / LDMIA encodings as presented on the op port
//   state_t  : sequencer FSM states
//   LR_I/PC_I: register-file indices that list bit 8 maps onto
package reglist_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_POP   = 2'b01,
    OP_STMIA = 2'b10,
    OP_LDMIA = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_WRITE = 3'd3,
    ST_WB    = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [3:0] LR_I   = 4'd14;
  localparam logic [3:0] PC_I   = 4'd15;
  localparam int         LIST_W = 9;

  function automatic logic op_is_store(op_t op);
    return (op == OP_PUSH) || (op == OP_STMIA);
  endfunction

endpackage

// File: rtl/reglist_prio_enc.sv
// Lowest-set-bit encoder for the 9-bit register list (purely combinational).
//   list  in  9  pending register list
//   idx   out 4  index of the lowest set bit (0..8), 0 when list is empty
//   valid out 1  at least one bit set
module reglist_prio_enc
  import reglist_sequencer_pkg::*;
(
  input  logic [LIST_W-1:0] list,
  output logic [3:0]        idx,
  output logic              valid
);

  always_comb begin
    idx   = '0;
    valid = |list;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (list[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/reglist_sequencer.sv
// Multi-register transfer controller (PUSH/POP/STMIA/LDMIA).
// Walks the register list lowest index first, one req/ack memory beat per register,
// returns load data through the register-file write port and issues the base writeback.
//   clk, rst (async, active-low)
//   start/op/reg_list/base_addr/base_idx : launch request from decode, sampled in IDLE only
//   rd_data  : register-file read data for addr_Rs
//   mem_*    : data-memory beat interface (req held until ack)
//   ld_rd/addr_Rd/w_Rd/pc_load : register-file / PC write strobes for loads
//   wb_valid/wb_is_sp/wb_data  : final SP or Rn writeback
//   busy/done/err              : status
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// SETUP | count list, compute start address
// XFER  | memory beat in flight (mem_req=1) or one-cycle gap (mem_req=0)
// WRITE | load data presented on ld_rd / pc_load
// WB    | base writeback strobe (suppressed when list empty / LDMIA base loaded)
// DONE  | done pulse, busy low
module reglist_sequencer
  import reglist_sequencer_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ADDR_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [8:0]        reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [2:0]        base_idx,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        addr_Rs,
  output logic              ld_rd,
  output logic [3:0]        addr_Rd,
  output logic [DATA_W-1:0] w_Rd,
  output logic              pc_load,
  output logic              wb_valid,
  output logic              wb_is_sp,
  output logic [ADDR_W-1:0] wb_data
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  state_t            state;
  op_t               op_q;
  logic [LIST_W-1:0] list_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] start_addr_q;
  logic [3:0]        n_q;
  logic              base_hit_q;
  logic              empty_q;

  logic [3:0]        enc_idx;
  logic              enc_valid;
  logic [3:0]        map_idx;
  logic [3:0]        n_c;
  logic              is_store;
  logic              last_beat;
  logic              wb_en_c;
  logic [LIST_W-1:0] list_after;
  logic [ADDR_W-1:0] setup_addr_c;
  logic [ADDR_W-1:0] wb_val_c;

  reglist_prio_enc u_prio_enc (
    .list  (list_q),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    map_idx = enc_idx;
    if (enc_idx == 4'd8) map_idx = (op_q == OP_PUSH) ? LR_I : PC_I;
    n_c          = 4'($countones(list_q));
    is_store     = op_is_store(op_q);
    list_after   = list_q & ~(LIST_W'(1) << enc_idx);
    last_beat    = (list_after == '0);
    setup_addr_c = (op_q == OP_PUSH) ? base_q - STEP * ADDR_W'(n_c) : base_q;
    wb_val_c     = (op_q == OP_PUSH) ? start_addr_q : base_q + STEP * ADDR_W'(n_q);
    // LDMIA with the base in its own list: the loaded value wins over writeback.
    wb_en_c      = !((op_q == OP_LDMIA) && base_hit_q);
  end

  // Store data comes straight off the register-file read port; addr_Rs is held
  // for the whole beat so this stays stable until ack.
  assign mem_wdata = (mem_req && mem_we) ? rd_data : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      op_q         <= OP_PUSH;
      list_q       <= '0;
      base_q       <= '0;
      start_addr_q <= '0;
      n_q          <= '0;
      base_hit_q   <= 1'b0;
      empty_q      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      addr_Rs      <= '0;
      ld_rd        <= 1'b0;
      addr_Rd      <= '0;
      w_Rd         <= '0;
      pc_load      <= 1'b0;
      wb_valid     <= 1'b0;
      wb_is_sp     <= 1'b0;
      wb_data      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q       <= op_t'(op);
            list_q     <= op[1] ? {1'b0, reg_list[7:0]} : reg_list;
            base_q     <= base_addr;
            base_hit_q <= reg_list[base_idx];
            busy       <= 1'b1;
            state      <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          n_q          <= n_c;
          start_addr_q <= setup_addr_c;
          if (n_c == '0) begin
            empty_q <= 1'b1;
            state   <= ST_WB;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= is_store;
            mem_addr <= setup_addr_c;
            addr_Rs  <= is_store ? map_idx : 4'd0;
            state    <= ST_XFER;
          end
        end

        ST_XFER: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
            addr_Rs <= is_store ? map_idx : 4'd0;
          end else if (mem_ack) begin
            mem_req  <= 1'b0;
            list_q   <= list_after;
            mem_addr <= mem_addr + STEP;
            if (!is_store) begin
              addr_Rd <= map_idx;
              w_Rd    <= mem_rdata;
              if (map_idx == PC_I) pc_load <= 1'b1;
              else                 ld_rd   <= 1'b1;
              state   <= ST_WRITE;
            end else if (last_beat) begin
              wb_valid <= wb_en_c;
              wb_is_sp <= (op_q == OP_PUSH) || (op_q == OP_POP);
              wb_data  <= wb_val_c;
              state    <= ST_WB;
            end
          end
        end

        ST_WRITE: begin
          ld_rd   <= 1'b0;
          pc_load <= 1'b0;
          if (enc_valid) begin
            mem_req <= 1'b1;
            state   <= ST_XFER;
          end else begin
            wb_valid <= wb_en_c;
            wb_is_sp <= (op_q == OP_PUSH) || (op_q == OP_POP);
            wb_data  <= wb_val_c;
            state    <= ST_WB;
          end
        end

        ST_WB: begin
          wb_valid <= 1'b0;
          wb_is_sp <= 1'b0;
          wb_data  <= '0;
          done     <= 1'b1;
          err      <= empty_q;
          busy     <= 1'b0;
          state    <= ST_DONE;
        end

        ST_DONE: begin
          done    <= 1'b0;
          err     <= 1'b0;
          empty_q <= 1'b0;
          state   <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
